// File: rtl/pipe_demux4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_demux4                                                   |
// | Purpose  : 1-to-4 valid/ready demultiplexer with a buffer per channel.   |
// |            The word on In is routed to the channel chosen by Sel.        |
// |            Each channel presents its buffered word on its own Out port   |
// |            with one cycle of latency.                                    |
// | Options  : PIPE_DEMUX_SKID_EN selects a 2-entry FIFO per channel, and    |
// |            in_ready then has no combinational path from out_ready.       |
// |            Without it, each channel has a 1-entry register and          |
// |            in_ready = !out_valid[Sel] || out_ready[Sel].                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_demux4 (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] In,
    input  logic [1:0]  Sel,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] Out1,
    output logic [31:0] Out2,
    output logic [31:0] Out3,
    output logic [31:0] Out4,
    output logic [3:0]  out_valid,
    input  logic [3:0]  out_ready,
    output logic        empty
);

    localparam int c_WIDTH = 32;
    localparam int c_NCH   = 4;

    // Head entry of each channel.  It is the word currently presented, and it
    // keeps its last value after the pop so the Out port holds steady.
    logic [c_WIDTH-1:0] r_head [c_NCH];
    logic [c_NCH-1:0]   r_hvalid;

    logic [c_NCH-1:0]   w_push;
    logic [c_NCH-1:0]   w_pop;
    logic [c_NCH-1:0]   w_room;

    assign w_pop = r_hvalid & out_ready;

`ifdef PIPE_DEMUX_SKID_EN
    // Second entry of each channel.  It is only ever occupied while the head
    // is occupied.
    logic [c_WIDTH-1:0] r_tail [c_NCH];
    logic [c_NCH-1:0]   r_tvalid;

    // A channel has room while its second entry is free.  out_ready is
    // deliberately kept out of this term.
    assign w_room = ~r_tvalid;
    assign empty  = ~(|r_hvalid) & ~(|r_tvalid);
`else
    // A single-entry channel can take a word if it is empty or is draining
    // during this cycle.
    assign w_room = ~r_hvalid | out_ready;
    assign empty  = ~(|r_hvalid);
`endif

    assign in_ready = ~RST & w_room[Sel];

    generate
        for (genvar k = 0; k < c_NCH; k++) begin : g_ch
            localparam logic [1:0] c_CH = 2'(k);

            assign w_push[k] = in_valid & in_ready & (Sel == c_CH);

`ifdef PIPE_DEMUX_SKID_EN
            // Two-entry FIFO: refill the head from the tail when popping,
            // and append the incoming word behind whatever remains.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_head[k]   <= '0;
                    r_tail[k]   <= '0;
                    r_hvalid[k] <= 1'b0;
                    r_tvalid[k] <= 1'b0;
                end else if (w_pop[k] && w_push[k]) begin
                    if (r_tvalid[k]) begin
                        r_head[k] <= r_tail[k];
                        r_tail[k] <= In;
                    end else begin
                        r_head[k] <= In;
                    end
                end else if (w_pop[k]) begin
                    if (r_tvalid[k]) begin
                        r_head[k]   <= r_tail[k];
                        r_tvalid[k] <= 1'b0;
                    end else begin
                        r_hvalid[k] <= 1'b0;
                    end
                end else if (w_push[k]) begin
                    if (r_hvalid[k]) begin
                        r_tail[k]   <= In;
                        r_tvalid[k] <= 1'b1;
                    end else begin
                        r_head[k]   <= In;
                        r_hvalid[k] <= 1'b1;
                    end
                end
            end
`else
            // Single-entry register: a push overrides a simultaneous pop, so
            // the new word follows the old one with no bubble.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_head[k]   <= '0;
                    r_hvalid[k] <= 1'b0;
                end else if (w_push[k]) begin
                    r_head[k]   <= In;
                    r_hvalid[k] <= 1'b1;
                end else if (w_pop[k]) begin
                    r_hvalid[k] <= 1'b0;
                end
            end
`endif
        end
    endgenerate

    assign out_valid = r_hvalid;
    assign Out1      = r_head[0];
    assign Out2      = r_head[1];
    assign Out3      = r_head[2];
    assign Out4      = r_head[3];

endmodule
`default_nettype wire

// File: tb/tb_pipe_demux4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_demux4                                                |
// | Purpose  : Self-checking bench for pipe_demux4.  It uses directed steps  |
// |            and a per-channel scoreboard.  The bench follows the          |
// |            PIPE_DEMUX_SKID_EN setting of the build.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipe_demux4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] In;
    logic [1:0]  Sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Out1, Out2, Out3, Out4;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        empty;

    pipe_demux4 dut (
        .CLK       (CLK),
        .RST       (RST),
        .In        (In),
        .Sel       (Sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out1      (Out1),
        .Out2      (Out2),
        .Out3      (Out3),
        .Out4      (Out4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .empty     (empty)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rx4    = 0;

    logic [31:0] sbq [0:3][$];
    logic [31:0] outs [4];

    always_comb begin
        outs[0] = Out1;
        outs[1] = Out2;
        outs[2] = Out3;
        outs[3] = Out4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor.  It samples on the falling edge, when inputs and
    // outputs are both stable.
    always @(negedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    n_checks++;
                    assert (sbq[k].size() > 0) else begin
                        n_fail++;
                        $error("FAIL sb_unexpected_ch%0d observed=%h expected=none", k, outs[k]);
                    end
                    if (sbq[k].size() > 0) begin
                        chk($sformatf("sb_data_ch%0d", k), outs[k], sbq[k].pop_front());
                        if (k == 3) n_rx4++;
                    end
                end
            end
            if (in_valid && in_ready) sbq[Sel].push_back(In);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        RST = 1'b1; In = '0; Sel = '0; in_valid = 1'b0; out_ready = '0;
        tick(); tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out1", Out1, 32'h0);
        chk("rst_out2", Out2, 32'h0);
        chk("rst_out3", Out3, 32'h0);
        chk("rst_out4", Out4, 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        RST = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'h1);

        // Single word to channel 3, then hold under backpressure
        In = 32'hDEADBEEF; Sel = 2'd2; in_valid = 1'b1;
        #1;
        chk("a_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("a_out_valid", 32'(out_valid), 32'h4);
        chk("a_out3", Out3, 32'hDEADBEEF);
        chk("a_empty", 32'(empty), 32'h0);
        tick(); tick();
        chk("a_hold_valid", 32'(out_valid), 32'h4);
        chk("a_hold_out3", Out3, 32'hDEADBEEF);

        // Channel 1 stalled with one word, then a second offer
        In = 32'h11; Sel = 2'd0; in_valid = 1'b1;
        tick();
        In = 32'h1;
        #1;
`ifdef PIPE_DEMUX_SKID_EN
        chk("b_second_accepted", 32'(in_ready), 32'h1);
        tick();
        chk("b_third_refused", 32'(in_ready), 32'h0);
        tick();
        chk("b_still_refused", 32'(in_ready), 32'h0);
`else
        chk("b_in_ready_low", 32'(in_ready), 32'h0);
        tick();
        chk("b_still_refused", 32'(in_ready), 32'h0);
`endif
        chk("b_out1", Out1, 32'h11);
        chk("b_out_valid", 32'(out_valid), 32'h5);

        // Sel moves away from the stalled channel while in_valid is held
        In = 32'h55; Sel = 2'd3;
        #1;
        chk("c_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("c_out_valid", 32'(out_valid), 32'hD);
        chk("c_out4", Out4, 32'h55);
        chk("c_out1_stable", Out1, 32'h11);

        // Push and pop on channel 2 in the same cycle
        In = 32'h77; Sel = 2'd1; in_valid = 1'b1;
        tick();
        chk("d_out2_first", Out2, 32'h77);
        chk("d_out_valid", 32'(out_valid), 32'hF);
        In = 32'hA5; out_ready = 4'b0010;
        #1;
        chk("d_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("d_out2", Out2, 32'hA5);
        chk("d_valid2", 32'(out_valid[1]), 32'h1);

        // Drain everything
        out_ready = 4'hF;
        tick(); tick(); tick(); tick();
        out_ready = 4'h0;
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("drain_empty", 32'(empty), 32'h1);
        chk("drain_sb_left", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'h0);
        chk("drain_out3_hold", Out3, 32'hDEADBEEF);

        // Stream 1, 2, 3 into channel 4 with random backpressure
        n_rx4 = 0;
        sent  = 0;
        for (int c = 0; c < 200 && sent < 3; c++) begin
            out_ready = {1'($urandom_range(0, 1)), 3'b000};
            In = 32'(sent + 1); Sel = 2'd3; in_valid = 1'b1;
            #1;
            if (in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        chk("e_all_sent", 32'(sent), 32'h3);
        for (int c = 0; c < 100 && (sbq[3].size() > 0 || out_valid[3]); c++) begin
            out_ready = {1'($urandom_range(0, 1)), 3'b000};
            tick();
        end
        out_ready = 4'h0;
        chk("e_sb_left", 32'(sbq[3].size()), 32'h0);
        chk("e_rx_count", 32'(n_rx4), 32'h3);
        chk("e_out4_last", Out4, 32'h3);
        chk("e_empty", 32'(empty), 32'h1);

        // Reset with all channels holding data
        for (int k = 0; k < 4; k++) begin
            In = 32'h100 + 32'(k); Sel = 2'(k); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("f_loaded", 32'(out_valid), 32'hF);
        RST = 1'b1;
        tick();
        chk("f_out_valid", 32'(out_valid), 32'h0);
        chk("f_out1", Out1, 32'h0);
        chk("f_out2", Out2, 32'h0);
        chk("f_out3", Out3, 32'h0);
        chk("f_out4", Out4, 32'h0);
        chk("f_empty", 32'(empty), 32'h1);
        chk("f_in_ready", 32'(in_ready), 32'h0);
        RST = 1'b0;
        tick();
        chk("f_after_empty", 32'(empty), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_demux4.md
PIPE_DEMUX4 -- requirements
Module: pipe_demux4

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port In, input, 32 bits: source data word.
REQ-004 The block SHALL have port Sel, input, 2 bits: destination channel (0 = channel 1 ... 3 = channel 4).
REQ-005 The block SHALL have port in_valid, input, 1 bit: the source offers In/Sel this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the channel selected by Sel can accept a word.
REQ-007 The block SHALL have ports Out1, Out2, Out3, Out4, output, 32 bits each: per-channel data.
REQ-008 The block SHALL have port out_valid, output, 4 bits: bit k flags valid data on channel k+1.
REQ-009 The block SHALL have port out_ready, input, 4 bits: bit k means the sink of channel k+1 accepts.
REQ-010 The block SHALL have port empty, output, 1 bit: all channel buffers are empty.

Function
REQ-011 An input transfer SHALL occur on a rising edge when in_valid && in_ready; the word SHALL be written only into the buffer of channel Sel.
REQ-012 in_ready SHALL depend only on Sel, buffer state and (when the macro is undefined) out_ready[Sel]; it SHALL NOT depend on in_valid.
REQ-013 An output transfer on channel k SHALL occur on a rising edge when out_valid[k] && out_ready[k].
REQ-014 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on Out(k+1) with out_valid[k]=1 immediately after edge N, provided the channel was empty.
REQ-015 While out_valid[k]=1 and out_ready[k]=0, Out(k+1) and out_valid[k] SHALL remain stable.
REQ-016 When out_valid[k]=0, Out(k+1) SHALL hold its last presented value.
REQ-017 When a push and a pop hit the same channel in the same cycle, occupancy SHALL be unchanged, and the next word SHALL be presented after the edge.
REQ-018 Channels SHALL be independent: a stalled channel SHALL NOT block inputs routed to other channels.
REQ-019 Word order within a channel SHALL be preserved.
REQ-020 The source MAY change Sel while in_valid=1 and in_ready=0; no word SHALL be accepted in that case.
REQ-021 When in_valid=0, the input side SHALL NOT change any buffer.
REQ-022 empty SHALL equal 1 exactly when out_valid = 4'b0000 and no buffered words remain.

Reset
REQ-023 While RST=1 at a rising edge, all buffers SHALL be cleared: out_valid=4'b0000, Out1..Out4=32'h0, empty=1.
REQ-024 in_ready SHALL be 0 while RST=1.
REQ-025 A reset asserted mid-operation SHALL discard all stored words without any output transfer.

Configuration
REQ-026 When macro PIPE_DEMUX_SKID_EN is defined, each channel SHALL contain a 2-entry FIFO, and in_ready SHALL be 1 when the selected channel holds fewer than 2 words; in_ready SHALL have no combinational path from out_ready.
REQ-027 When PIPE_DEMUX_SKID_EN is undefined, each channel SHALL contain a 1-entry register, and in_ready SHALL equal (!out_valid[Sel] || out_ready[Sel]).

Verification
REQ-028 The bench SHALL cover: after reset, In=32'hDEADBEEF, Sel=2, in_valid=1 for 1 cycle -> next cycle out_valid=4'b0100 and Out3=32'hDEADBEEF; Out3 and out_valid stay stable with out_ready=0.
REQ-029 The bench SHALL cover: channel 1 holds a word with out_ready[0]=0, then In=32'h1, Sel=0 -> in_ready=0 without the macro; with the macro, the word is accepted and the second offer is refused.
REQ-030 The bench SHALL cover: channel 1 stalled, In=32'h55, Sel=3 -> accepted; out_valid[3]=1 and Out4=32'h55 the next cycle.
REQ-031 The bench SHALL cover: a full channel 2 with out_ready[1]=1 and Sel=1, In=32'hA5 in the same cycle -> simultaneous pop/push; Out2=32'hA5 next cycle with out_valid[1]=1.
REQ-032 The bench SHALL cover: words 1, 2, 3 streamed to channel 4 with random out_ready -> received in order 1, 2, 3, with no loss or duplication.
REQ-033 The bench SHALL cover: RST=1 asserted with all channels holding data -> next cycle out_valid=0, Out1..Out4=0, empty=1.
